// File: rtl/mux3_sel_sequencer_pkg.sv
// Shared select codes, FSM state type and pointer helper for the 3:1 mux sequencer.
package mux3_sel_sequencer_pkg;

  localparam logic [1:0] SEL_IN0     = 2'b00;
  localparam logic [1:0] SEL_IN1     = 2'b01;
  localparam logic [1:0] SEL_IN2     = 2'b10;
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Round-robin successor; the unused code 3 folds back to 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      SEL_IN0: nxt = SEL_IN1;
      SEL_IN1: nxt = SEL_IN2;
      default: nxt = SEL_IN0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mux3_sel_sequencer_rr_pick3.sv
// Combinational round-robin picker over three requesters, starting the search at ptr.
module mux3_sel_sequencer_rr_pick3
  import mux3_sel_sequencer_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] w_cand;

  always_comb begin
    win    = 3'b000;
    idx    = SEL_IN0;
    any    = 1'b0;
    w_cand = (ptr == SEL_ILLEGAL) ? SEL_IN0 : ptr;
    for (int k = 0; k < 3; k++) begin
      if (!any && req[w_cand]) begin
        any         = 1'b1;
        idx         = w_cand;
        win[w_cand] = 1'b1;
      end
      w_cand = next_idx(w_cand);
    end
  end

endmodule

// File: rtl/mux3_sel_sequencer.sv
// Round-robin select sequencer for a 3:1 mux: bounded hold per grant, registered outputs,
// select never takes the illegal code.
module mux3_sel_sequencer
  import mux3_sel_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       req,
  output logic [1:0]       sel,
  output logic [2:0]       grant,
  output logic             sel_valid,
  output logic             switch_pulse,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_CYCLES - 1);

  state_e           r_state, w_state_d;
  logic [1:0]       r_sel, w_sel_d;
  logic [2:0]       r_grant, w_grant_d;
  logic             r_sel_valid, w_sel_valid_d;
  logic             r_switch_pulse, w_switch_pulse_d;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_d;
  logic [1:0]       r_ptr, w_ptr_d;
  logic [1:0]       r_last_idx, w_last_idx_d;
  logic             r_last_vld, w_last_vld_d;

  logic [2:0] w_arb_req;
  logic [2:0] w_win;
  logic [1:0] w_idx;
  logic       w_any;
  logic       w_take;

  // While granted, r_ptr already points past the holder, so masking it out yields
  // both the drop rearbitration and the next-in-line search on hold expiry.
  assign w_arb_req = (r_state == ST_GRANT) ? (req & ~r_grant) : req;

  mux3_sel_sequencer_rr_pick3 u_rr_pick3 (
    .req (w_arb_req),
    .ptr (r_ptr),
    .win (w_win),
    .idx (w_idx),
    .any (w_any)
  );

  always_comb begin
    w_state_d        = r_state;
    w_sel_d          = r_sel;
    w_grant_d        = r_grant;
    w_switch_pulse_d = 1'b0;
    w_hold_cnt_d     = r_hold_cnt;
    w_ptr_d          = r_ptr;
    w_last_idx_d     = r_last_idx;
    w_last_vld_d     = r_last_vld;
    w_take           = 1'b0;

    if (!enable) begin
      w_state_d    = ST_IDLE;
      w_grant_d    = 3'b000;
      w_hold_cnt_d = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: w_take = w_any;
        ST_GRANT: begin
          if ((req & r_grant) == 3'b000) begin
            if (w_any) begin
              w_take = 1'b1;
            end else begin
              w_state_d    = ST_IDLE;
              w_grant_d    = 3'b000;
              w_hold_cnt_d = '0;
            end
          end else if (r_hold_cnt == HoldMax) begin
            w_hold_cnt_d = '0;
            w_take       = w_any;
          end else begin
            w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
          end
        end
        default: w_state_d = ST_IDLE;
      endcase

      if (w_take) begin
        w_state_d        = ST_GRANT;
        w_sel_d          = w_idx;
        w_grant_d        = w_win;
        w_hold_cnt_d     = '0;
        w_ptr_d          = next_idx(w_idx);
        w_switch_pulse_d = !r_last_vld || (w_idx != r_last_idx);
        w_last_idx_d     = w_idx;
        w_last_vld_d     = 1'b1;
      end
    end

    w_sel_valid_d = (w_grant_d != 3'b000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_sel          <= SEL_IN0;
      r_grant        <= 3'b000;
      r_sel_valid    <= 1'b0;
      r_switch_pulse <= 1'b0;
      r_hold_cnt     <= '0;
      r_ptr          <= SEL_IN0;
      r_last_idx     <= SEL_IN0;
      r_last_vld     <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_sel          <= w_sel_d;
      r_grant        <= w_grant_d;
      r_sel_valid    <= w_sel_valid_d;
      r_switch_pulse <= w_switch_pulse_d;
      r_hold_cnt     <= w_hold_cnt_d;
      r_ptr          <= w_ptr_d;
      r_last_idx     <= w_last_idx_d;
      r_last_vld     <= w_last_vld_d;
    end
  end

  assign sel          = r_sel;
  assign grant        = r_grant;
  assign sel_valid    = r_sel_valid;
  assign switch_pulse = r_switch_pulse;
  assign hold_cnt     = r_hold_cnt;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (r_sel != SEL_ILLEGAL)
      else $error("mux3_sel_sequencer: sel drove illegal code 2'b11");
    end
  end
`endif

endmodule

// File: tb/tb_mux3_sel_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural
// round-robin model.
module tb_mux3_sel_sequencer;

  localparam int H     = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [2:0]       req;
  logic [1:0]       sel;
  logic [2:0]       grant;
  logic             sel_valid;
  logic             switch_pulse;
  logic [CNT_W-1:0] hold_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: granted index (-1 = idle), hold count, pointer, last granted (-1 = none).
  int m_g, m_hold, m_ptr, m_last, m_sel, m_pulse;

  mux3_sel_sequencer #(
    .HOLD_CYCLES (H),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req          (req),
    .sel          (sel),
    .grant        (grant),
    .sel_valid    (sel_valid),
    .switch_pulse (switch_pulse),
    .hold_cnt     (hold_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g = -1; m_hold = 0; m_ptr = 0; m_last = -1; m_sel = 0; m_pulse = 0;
  endtask

  task automatic model_grant(input int w);
    m_pulse = (w != m_last) ? 1 : 0;
    m_g     = w;
    m_last  = w;
    m_hold  = 0;
    m_ptr   = (w + 1) % 3;
    m_sel   = w;
  endtask

  task automatic model_step(input logic en, input logic [2:0] r);
    int w;
    logic [2:0] others;
    m_pulse = 0;
    if (!en) begin
      m_g = -1; m_hold = 0;
    end else if (m_g < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) model_grant(w);
    end else if (!r[m_g]) begin
      w = pick(r, (m_g + 1) % 3);
      if (w >= 0) model_grant(w);
      else begin
        m_g = -1; m_hold = 0;
      end
    end else if (m_hold == H - 1) begin
      others       = r;
      others[m_g]  = 1'b0;
      w = pick(others, (m_g + 1) % 3);
      if (w >= 0) model_grant(w);
      else m_hold = 0;
    end else begin
      m_hold = m_hold + 1;
    end
  endtask

  function automatic logic [9:0] exp_vec();
    logic [2:0] g;
    g = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
    return {2'(m_sel), g, (m_g >= 0), 1'(m_pulse), 3'(m_hold)};
  endfunction

  // Applies inputs, takes one edge, advances the model and settles 1 time unit after.
  task automatic step(input logic en, input logic [2:0] r);
    enable = en;
    req    = r;
    @(posedge clk);
    model_step(en, r);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 3'b000;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    n_checks++;
    if ({sel, grant, sel_valid, switch_pulse, hold_cnt} !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_state: got %b exp %b", {sel, grant, sel_valid, switch_pulse, hold_cnt},
               10'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b000);
      n_checks++;
      if ({sel, grant, sel_valid, switch_pulse, hold_cnt} !== exp_vec()) begin
        n_errors++;
        $display("FAIL idle_no_req cyc%0d: got %b exp %b", i,
                 {sel, grant, sel_valid, switch_pulse, hold_cnt}, exp_vec());
      end
    end
  endtask

  task automatic test_single_req();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b010);
      n_checks++;
      if ({sel, grant, sel_valid, switch_pulse, hold_cnt} !== exp_vec()) begin
        n_errors++;
        $display("FAIL single_req cyc%0d: got %b exp %b", i,
                 {sel, grant, sel_valid, switch_pulse, hold_cnt}, exp_vec());
      end
    end
  endtask

  task automatic test_all_req();
    logic [1:0] es;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 3'b111);
      es = 2'((i / H) % 3);
      n_checks++;
      if (sel !== es || switch_pulse !== ((i % H) == 0)) begin
        n_errors++;
        $display("FAIL rotation cyc%0d: got sel=%b sw=%b exp sel=%b sw=%b", i, sel,
                 switch_pulse, es, (i % H) == 0);
      end
      n_checks++;
      if ({sel, grant, sel_valid, switch_pulse, hold_cnt} !== exp_vec()) begin
        n_errors++;
        $display("FAIL rotation_model cyc%0d: got %b exp %b", i,
                 {sel, grant, sel_valid, switch_pulse, hold_cnt}, exp_vec());
      end
    end
  endtask

  task automatic test_drop_wrap();
    do_reset();
    step(1'b1, 3'b100);
    step(1'b1, 3'b001);
    n_checks++;
    if (sel !== 2'b00 || grant !== 3'b001 || switch_pulse !== 1'b1) begin
      n_errors++;
      $display("FAIL drop_wrap: got sel=%b grant=%b sw=%b exp sel=00 grant=001 sw=1", sel,
               grant, switch_pulse);
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3'b010);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b111);
      n_checks++;
      if (grant !== 3'b000 || sel !== 2'b01 || sel_valid !== 1'b0 || hold_cnt !== '0) begin
        n_errors++;
        $display("FAIL enable_gap cyc%0d: got sel=%b grant=%b v=%b hold=%0d exp 01/000/0/0",
                 i, sel, grant, sel_valid, hold_cnt);
      end
    end
    step(1'b1, 3'b111);
    n_checks++;
    if (grant !== 3'b100 || sel !== 2'b10 || switch_pulse !== 1'b1) begin
      n_errors++;
      $display("FAIL regrant_ptr: got sel=%b grant=%b sw=%b exp 10/100/1", sel, grant,
               switch_pulse);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 3'b010);
    step(1'b1, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({sel, grant, sel_valid, switch_pulse, hold_cnt} !== 10'b0) begin
      n_errors++;
      $display("FAIL async_reset: got %b exp %b", {sel, grant, sel_valid, switch_pulse,
               hold_cnt}, 10'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b111);
    n_checks++;
    if (grant !== 3'b001 || sel !== 2'b00) begin
      n_errors++;
      $display("FAIL post_reset_grant: got sel=%b grant=%b exp 00/001", sel, grant);
    end
  endtask

  task automatic test_random();
    logic       en;
    logic [2:0] r;
    do_reset();
    r = 3'b000;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      step(en, r);
      n_checks++;
      if ({sel, grant, sel_valid, switch_pulse, hold_cnt} !== exp_vec() || sel === 2'b11) begin
        n_errors++;
        $display("FAIL random cyc%0d en=%b req=%b: got %b exp %b", i, en, r,
                 {sel, grant, sel_valid, switch_pulse, hold_cnt}, exp_vec());
      end
    end
  endtask

  initial begin
    enable = 1'b0;
    req    = 3'b000;
    test_reset();
    test_single_req();
    test_all_req();
    test_drop_wrap();
    test_enable_gap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
